reg_status_ctrl: RTL and testbench
==================================

# reg_status_ctrl

Register-status controller for the Tomasulo core. It owns the 8-entry architectural register bank, where each entry holds a 9-bit data word and a 9-bit producer label. It sequences post-reset initialization, renames a destination register at issue, and retires results from the common data bus (CDB) by label match. It sits between the issue stage (rename and operand read) and the CDB.

## Interface
Parameters:
- NREG, 8, number of registers (power of two)
- W, 9, data and label width
- INIT_DATA, 9'd2, data value written to every register by the init walk

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  rename request
- issue_rd  in  log2(NREG)  destination register to rename
- issue_tag  in  W  reservation-station label that will produce issue_rd
- issue_ready  out  1  rename accepted this cycle when high
- rs_addr, rt_addr  in  log2(NREG)  operand read addresses
- rs_data, rt_data  out  W  registered operand data
- rs_label, rt_label  out  W  registered operand label; NO_TAG means the data is valid
- cdb_valid  in  1  CDB broadcast
- cdb_tag  in  W  label of the broadcasting producer
- cdb_data  in  W  broadcast result
- init_busy  out  1  init walk in progress
- pending_count  out  log2(NREG)+1  number of entries whose label is not NO_TAG

## Operation
- NO_TAG = all-ones (9'h1FF). It marks an entry with no pending producer.
- The FSM has two states: INIT and RUN.
- INIT:
  - Counter idx walks 0..NREG-1, one entry per cycle.
  - Each cycle writes data=INIT_DATA and label=NO_TAG to entry idx.
  - On idx==NREG-1 the FSM moves to RUN.
  - issue_ready=0 and init_busy=1 throughout. CDB and issue inputs are ignored.
- RUN:
  - issue_ready=1 and init_busy=0.
  - Rename: when issue_valid and issue_tag!=NO_TAG, label[issue_rd] <= issue_tag. Data is unchanged.
  - If issue_valid and issue_tag==NO_TAG, the request is dropped with no state change.
  - Retire: when cdb_valid and cdb_tag!=NO_TAG, every entry with label==cdb_tag gets data <= cdb_data and label <= NO_TAG. Multiple matches all update.
  - If cdb_tag==NO_TAG, the broadcast is ignored.
- Issue and CDB hitting the same entry in one cycle (the entry's old label matches cdb_tag and the entry is renamed): data <= cdb_data, label <= issue_tag. The rename wins the label.
- Reads:
  - rs_data/rs_label and rt_data/rt_label are registered from the entries at rs_addr/rt_addr.
  - The values read are those before this cycle's updates unless bypass is enabled (see Configuration).
  - Reads are valid in both states.
- pending_count is registered and equals the population of non-NO_TAG labels after this cycle's updates.

## Timing
- Reset: state=INIT, idx=0, init_busy=1, issue_ready=0, rs_data=rt_data=0, rs_label=rt_label=NO_TAG, pending_count=0. Entry contents are undefined until the init walk writes them.
- The init walk takes exactly NREG cycles after rst deasserts. issue_ready rises in cycle NREG.
- Read latency is 1 cycle.
- Rename and retire take effect at the clock edge and are visible to a read issued in the next cycle.
- Reset asserted mid-operation: on the next edge the block returns to INIT with idx=0 and the walk restarts. Pending labels are discarded.
- There is no backpressure in RUN. issue_ready is a pure function of state.

## Configuration
- REG_CDB_BYPASS_EN:
  - Defined: the read outputs forward the same-cycle CDB, so an addressed entry whose label matches a valid cdb_tag returns cdb_data with label NO_TAG. A same-cycle rename of the addressed entry is not forwarded.
  - Undefined: reads return only pre-update state.

## Structure
- A shared package holds:
  - NO_TAG
  - W
  - the state enum (INIT, RUN)
  - the label/data entry typedef
- One natural sub-module is reg_status_entry: a single entry with rename and retire ports, its tag compare, and a priority rule where rename wins the label. The controller instantiates NREG copies, the FSM, the read muxes and the popcount.

## Test plan
- Release reset, hold issue_valid=1: init_busy=1 for 8 cycles, then issue_ready=1. Reading any register returns data=2, label=9'h1FF.
- Rename r3 with tag 9'h005, then read r3: label=9'h005, data=2, pending_count=1.
- With r3 and r5 both labeled 9'h005, CDB tag 9'h005 with data 9'h0AA: both read data=9'h0AA, label=9'h1FF, pending_count=0.
- Same cycle: CDB tag 9'h005 with data 9'h033, plus a rename of r3 (label 9'h005) to 9'h007: r3 data=9'h033, label=9'h007.
- Assert rst for 1 cycle mid-run with 3 pending entries: pending_count=0 and init_busy=1 next cycle. After 8 more cycles, all entries read data=2, label=9'h1FF.
- With REG_CDB_BYPASS_EN: read r3 while the CDB retires r3's tag with 9'h044: the next-cycle rs_data=9'h044, rs_label=9'h1FF. Without the macro: rs_label is the old tag.

Source files
------------

// File: rtl/reg_status_ctrl_pkg.sv
// rtl/reg_status_ctrl_pkg.sv - shared widths, NO_TAG, FSM state and entry types for reg_status_ctrl
package reg_status_ctrl_pkg;

  localparam int W = 9;
  localparam logic [W-1:0] NO_TAG = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] label;
  } entry_t;

endpackage

// File: rtl/reg_status_entry.sv
// rtl/reg_status_entry.sv - one register-status entry: init write, CDB retire by tag, rename wins the label
module reg_status_entry
  import reg_status_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         init_wr,
  input  logic [W-1:0] init_data,
  input  logic         rename_en,
  input  logic [W-1:0] rename_tag,
  input  logic         retire_en,
  input  logic [W-1:0] cdb_tag,
  input  logic [W-1:0] cdb_data,
  output logic [W-1:0] data,
  output logic [W-1:0] label,
  output logic [W-1:0] label_nxt
);

  entry_t cur, nxt;
  logic   hit;

  always_comb begin
    nxt = cur;
    hit = retire_en && (cur.label == cdb_tag);
    if (init_wr) begin
      nxt.data  = init_data;
      nxt.label = NO_TAG;
    end else begin
      if (hit) begin
        nxt.data  = cdb_data;
        nxt.label = NO_TAG;
      end
      if (rename_en) nxt.label = rename_tag;
    end
  end

  // Only the label is reset so pending producers are dropped at once; data waits for the walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur.label <= NO_TAG;
    end else begin
      cur <= nxt;
    end
  end

  assign data      = cur.data;
  assign label     = cur.label;
  assign label_nxt = nxt.label;

endmodule

// File: rtl/reg_status_ctrl.sv
// rtl/reg_status_ctrl.sv - register-status controller: init walk, rename, CDB retire, registered reads (REG_CDB_BYPASS_EN)
module reg_status_ctrl
  import reg_status_ctrl_pkg::*;
#(
  parameter int          NREG      = 8,
  parameter int          W         = reg_status_ctrl_pkg::W,
  parameter logic [W-1:0] INIT_DATA = 9'd2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [$clog2(NREG)-1:0]   issue_rd,
  input  logic [W-1:0]              issue_tag,
  output logic                      issue_ready,
  input  logic [$clog2(NREG)-1:0]   rs_addr,
  input  logic [$clog2(NREG)-1:0]   rt_addr,
  output logic [W-1:0]              rs_data,
  output logic [W-1:0]              rt_data,
  output logic [W-1:0]              rs_label,
  output logic [W-1:0]              rt_label,
  input  logic                      cdb_valid,
  input  logic [W-1:0]              cdb_tag,
  input  logic [W-1:0]              cdb_data,
  output logic                      init_busy,
  output logic [$clog2(NREG):0]     pending_count
);

  localparam int AW = $clog2(NREG);

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          run, retire_en, rename_ok;
  logic [W-1:0]  ent_data  [NREG];
  logic [W-1:0]  ent_label [NREG];
  logic [W-1:0]  ent_lnxt  [NREG];
  logic [AW:0]   pend_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (state == ST_INIT) begin
      idx_nxt = idx + 1'b1;
      if (idx == AW'(NREG - 1)) state_nxt = ST_RUN;
    end
  end

  assign run         = (state == ST_RUN);
  assign issue_ready = run;
  assign init_busy   = !run;
  assign retire_en   = run && cdb_valid && (cdb_tag != NO_TAG);
  assign rename_ok   = run && issue_valid && (issue_tag != NO_TAG);

  for (genvar i = 0; i < NREG; i++) begin : g_ent
    reg_status_entry u_ent (
      .clk        (clk),
      .rst        (rst),
      .init_wr    (!run && (idx == AW'(i))),
      .init_data  (INIT_DATA),
      .rename_en  (rename_ok && (issue_rd == AW'(i))),
      .rename_tag (issue_tag),
      .retire_en  (retire_en),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .data       (ent_data[i]),
      .label      (ent_label[i]),
      .label_nxt  (ent_lnxt[i])
    );
  end

  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_nxt = pend_nxt + (AW+1)'(ent_lnxt[i] != NO_TAG);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_data       <= '0;
      rt_data       <= '0;
      rs_label      <= NO_TAG;
      rt_label      <= NO_TAG;
      pending_count <= '0;
    end else begin
      pending_count <= pend_nxt;
`ifdef REG_CDB_BYPASS_EN
      // Forward only the retiring result; a same-cycle rename is seen one cycle later.
      if (retire_en && ent_label[rs_addr] == cdb_tag) begin
        rs_data  <= cdb_data;
        rs_label <= NO_TAG;
      end else begin
        rs_data  <= ent_data[rs_addr];
        rs_label <= ent_label[rs_addr];
      end
      if (retire_en && ent_label[rt_addr] == cdb_tag) begin
        rt_data  <= cdb_data;
        rt_label <= NO_TAG;
      end else begin
        rt_data  <= ent_data[rt_addr];
        rt_label <= ent_label[rt_addr];
      end
`else
      rs_data  <= ent_data[rs_addr];
      rs_label <= ent_label[rs_addr];
      rt_data  <= ent_data[rt_addr];
      rt_label <= ent_label[rt_addr];
`endif
    end
  end

endmodule

// File: tb/tb_reg_status_ctrl.sv
// tb/tb_reg_status_ctrl.sv - directed and randomized checks of reg_status_ctrl against a behavioural model
module tb_reg_status_ctrl;

  localparam logic [8:0] NO = 9'h1FF;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [2:0] issue_rd;
  logic [8:0] issue_tag;
  logic       issue_ready;
  logic [2:0] rs_addr, rt_addr;
  logic [8:0] rs_data, rt_data, rs_label, rt_label;
  logic       cdb_valid;
  logic [8:0] cdb_tag, cdb_data;
  logic       init_busy;
  logic [3:0] pending_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_status_ctrl dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag), .issue_ready(issue_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .rs_label(rs_label), .rt_label(rt_label),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .init_busy(init_busy), .pending_count(pending_count)
  );

  // Behavioural model: register bank as plain arrays plus a "walk position" counter.
  logic [8:0] m_data [8];
  logic [8:0] m_label[8];
  bit         m_known[8];
  bit         m_run;
  int         m_walk;
  logic [8:0] e_rs_data, e_rt_data, e_rs_label, e_rt_label;
  bit         e_rs_known, e_rt_known;
  int         e_pend;

  function automatic void model_read(input int a, output logic [8:0] d, output logic [8:0] l, output bit k);
    d = m_data[a];
    l = m_label[a];
    k = m_known[a];
`ifdef REG_CDB_BYPASS_EN
    if (m_run && cdb_valid && cdb_tag != NO && m_label[a] == cdb_tag) begin
      d = cdb_data;
      l = NO;
      k = 1;
    end
`endif
  endfunction

  function automatic void model_step();
    bit hit[8];
    if (rst) begin
      m_run = 0;
      m_walk = 0;
      foreach (m_label[i]) begin
        m_label[i] = NO;
        m_known[i] = 0;
      end
      e_rs_data = 0; e_rt_data = 0; e_rs_label = NO; e_rt_label = NO;
      e_rs_known = 1; e_rt_known = 1;
    end else begin
      model_read(int'(rs_addr), e_rs_data, e_rs_label, e_rs_known);
      model_read(int'(rt_addr), e_rt_data, e_rt_label, e_rt_known);
      if (!m_run) begin
        m_data[m_walk] = 9'd2;
        m_label[m_walk] = NO;
        m_known[m_walk] = 1;
        m_walk++;
        if (m_walk == 8) m_run = 1;
      end else begin
        foreach (hit[i]) hit[i] = cdb_valid && cdb_tag != NO && m_label[i] == cdb_tag;
        foreach (hit[i]) if (hit[i]) begin
          m_data[i] = cdb_data;
          m_label[i] = NO;
        end
        if (issue_valid && issue_tag != NO) m_label[issue_rd] = issue_tag;
      end
    end
    e_pend = 0;
    foreach (m_label[i]) if (m_label[i] != NO) e_pend++;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; issue_valid = 0; issue_rd = 0; issue_tag = NO;
    cdb_valid = 0; cdb_tag = NO; cdb_data = 0;
  endtask

  task automatic test_reset();
    idle();
    rs_addr = 0; rt_addr = 0;
    rst = 1;
    tick();
    tick();
    n_vec++; if (init_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b exp=1", init_busy); end
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", issue_ready); end
    n_vec++; if (rs_data !== 9'd0 || rt_data !== 9'd0) begin n_err++; $display("FAIL reset_data got=%h/%h exp=0/0", rs_data, rt_data); end
    n_vec++; if (rs_label !== NO || rt_label !== NO) begin n_err++; $display("FAIL reset_label got=%h/%h exp=1ff", rs_label, rt_label); end
    n_vec++; if (pending_count !== 4'd0) begin n_err++; $display("FAIL reset_pend got=%0d exp=0", pending_count); end
  endtask

  task automatic test_init_walk();
    idle();
    issue_valid = 1; issue_rd = 3; issue_tag = 9'h005;
    cdb_valid = 1; cdb_tag = 9'h005; cdb_data = 9'h123;
    for (int c = 0; c < 8; c++) begin
      n_vec++; if (init_busy !== 1'b1 || issue_ready !== 1'b0) begin
        n_err++; $display("FAIL walk_busy c=%0d got busy=%b ready=%b exp busy=1 ready=0", c, init_busy, issue_ready);
      end
      tick();
    end
    idle();
    n_vec++; if (issue_ready !== 1'b1 || init_busy !== 1'b0) begin
      n_err++; $display("FAIL walk_done got ready=%b busy=%b exp ready=1 busy=0", issue_ready, init_busy);
    end
    n_vec++; if (pending_count !== 4'd0) begin n_err++; $display("FAIL walk_pend got=%0d exp=0", pending_count); end
    for (int r = 0; r < 8; r++) begin
      rs_addr = 3'(r); rt_addr = 3'(7 - r);
      tick();
      n_vec++; if (rs_data !== 9'd2 || rs_label !== NO || rt_data !== 9'd2 || rt_label !== NO) begin
        n_err++; $display("FAIL walk_read r=%0d got rs=%h/%h rt=%h/%h exp 002/1ff", r, rs_data, rs_label, rt_data, rt_label);
      end
    end
  endtask

  task automatic test_rename();
    idle();
    issue_valid = 1; issue_rd = 3; issue_tag = 9'h005;
    tick();
    idle();
    rs_addr = 3;
    tick();
    n_vec++; if (rs_label !== 9'h005 || rs_data !== 9'd2) begin
      n_err++; $display("FAIL rename_r3 got=%h/%h exp data=002 label=005", rs_data, rs_label);
    end
    n_vec++; if (pending_count !== 4'd1) begin n_err++; $display("FAIL rename_pend got=%0d exp=1", pending_count); end
    issue_valid = 1; issue_rd = 4; issue_tag = NO;
    tick();
    idle();
    n_vec++; if (pending_count !== 4'd1) begin n_err++; $display("FAIL notag_drop got=%0d exp=1", pending_count); end
  endtask

  task automatic test_retire_multi();
    idle();
    issue_valid = 1; issue_rd = 5; issue_tag = 9'h005;
    tick();
    idle();
    cdb_valid = 1; cdb_tag = NO; cdb_data = 9'h0EE;
    tick();
    n_vec++; if (pending_count !== 4'd2) begin n_err++; $display("FAIL cdb_notag got=%0d exp=2", pending_count); end
    cdb_valid = 1; cdb_tag = 9'h005; cdb_data = 9'h0AA;
    tick();
    idle();
    rs_addr = 3; rt_addr = 5;
    tick();
    n_vec++; if (rs_data !== 9'h0AA || rs_label !== NO || rt_data !== 9'h0AA || rt_label !== NO) begin
      n_err++; $display("FAIL retire_multi got rs=%h/%h rt=%h/%h exp 0aa/1ff", rs_data, rs_label, rt_data, rt_label);
    end
    n_vec++; if (pending_count !== 4'd0) begin n_err++; $display("FAIL retire_pend got=%0d exp=0", pending_count); end
  endtask

  task automatic test_same_cycle();
    idle();
    issue_valid = 1; issue_rd = 3; issue_tag = 9'h005;
    tick();
    idle();
    cdb_valid = 1; cdb_tag = 9'h005; cdb_data = 9'h033;
    issue_valid = 1; issue_rd = 3; issue_tag = 9'h007;
    tick();
    idle();
    rs_addr = 3;
    tick();
    n_vec++; if (rs_data !== 9'h033 || rs_label !== 9'h007) begin
      n_err++; $display("FAIL same_cycle got=%h/%h exp data=033 label=007", rs_data, rs_label);
    end
  endtask

  task automatic test_bypass();
    idle();
    rs_addr = 3;
    cdb_valid = 1; cdb_tag = 9'h007; cdb_data = 9'h044;
    tick();
    idle();
`ifdef REG_CDB_BYPASS_EN
    n_vec++; if (rs_data !== 9'h044 || rs_label !== NO) begin
      n_err++; $display("FAIL bypass_read got=%h/%h exp 044/1ff", rs_data, rs_label);
    end
`else
    n_vec++; if (rs_data !== 9'h033 || rs_label !== 9'h007) begin
      n_err++; $display("FAIL nobypass_read got=%h/%h exp 033/007", rs_data, rs_label);
    end
`endif
    tick();
    n_vec++; if (rs_data !== 9'h044 || rs_label !== NO) begin
      n_err++; $display("FAIL after_retire got=%h/%h exp 044/1ff", rs_data, rs_label);
    end
  endtask

  task automatic test_mid_reset();
    idle();
    for (int r = 0; r < 3; r++) begin
      issue_valid = 1; issue_rd = 3'(r); issue_tag = 9'(10 + r);
      tick();
    end
    idle();
    n_vec++; if (pending_count !== 4'd3) begin n_err++; $display("FAIL pre_reset_pend got=%0d exp=3", pending_count); end
    rst = 1;
    tick();
    rst = 0;
    n_vec++; if (pending_count !== 4'd0 || init_busy !== 1'b1) begin
      n_err++; $display("FAIL mid_reset got pend=%0d busy=%b exp pend=0 busy=1", pending_count, init_busy);
    end
    repeat (8) tick();
    for (int r = 0; r < 8; r++) begin
      rs_addr = 3'(r); rt_addr = 3'(r ^ 5);
      tick();
      n_vec++; if (rs_data !== 9'd2 || rs_label !== NO || rt_data !== 9'd2 || rt_label !== NO) begin
        n_err++; $display("FAIL rewalk_read r=%0d got rs=%h/%h rt=%h/%h exp 002/1ff", r, rs_data, rs_label, rt_data, rt_label);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] tags[7];
    tags = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, NO};
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd = 3'($urandom_range(0, 7));
      issue_tag = tags[$urandom_range(0, 6)];
      cdb_valid = $urandom_range(0, 1);
      cdb_tag = tags[$urandom_range(0, 6)];
      cdb_data = 9'($urandom);
      rs_addr = 3'($urandom_range(0, 7));
      rt_addr = 3'($urandom_range(0, 7));
      tick();
      n_vec++; if (issue_ready !== m_run || init_busy !== !m_run) begin
        n_err++; $display("FAIL rnd_state c=%0d got ready=%b busy=%b exp ready=%b", c, issue_ready, init_busy, m_run);
      end
      n_vec++; if (pending_count !== 4'(e_pend)) begin
        n_err++; $display("FAIL rnd_pend c=%0d got=%0d exp=%0d", c, pending_count, e_pend);
      end
      n_vec++; if (rs_label !== e_rs_label || (e_rs_known && rs_data !== e_rs_data)) begin
        n_err++; $display("FAIL rnd_rs c=%0d got=%h/%h exp=%h/%h", c, rs_data, rs_label, e_rs_data, e_rs_label);
      end
      n_vec++; if (rt_label !== e_rt_label || (e_rt_known && rt_data !== e_rt_data)) begin
        n_err++; $display("FAIL rnd_rt c=%0d got=%h/%h exp=%h/%h", c, rt_data, rt_label, e_rt_data, e_rt_label);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init_walk();
    test_rename();
    test_retire_multi();
    test_same_cycle();
    test_bypass();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
